rvc_expand_decoder: RTL and testbench
=====================================

Name:
rvc_expand_decoder

Overview:
RV32C decoder for the ID stage. It takes the low 16 bits of a fetched instruction and decodes every RV32C instruction directly into the same control bundle the 32-bit decoder produces: register indices, immediate and datapath selects. Outputs are registered, so the decode result appears one cycle after the instruction is presented. When the instruction is not compressed, or the encoding is reserved or illegal, all control outputs are NOP (zero).

Parameters:
None.

Ports:
clk  in  1  clock; all state updates on the rising edge
nrst  in  1  reset, asynchronous, active-low
inst  in  16  low halfword of the instruction
is_compressed  out  1  1 when inst[1:0] != 2'b11
dm_select  out  3  load type, funct3 encoding; 3'b010 = LW, 0 otherwise
imm_select  out  3  format/control-flow tag: 000 R/none, 001 I, 010 S, 011 branch-eqz, 100 U, 101 J, 110 branch-nez, 111 register jump
sel_data  out  2  writeback source: 00 ALU, 01 load data, 10 PC+2 (link)
store_select  out  2  store width: 10 word, 00 none
alu_op  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 10 pass-B
sel_opA  out  1  0 = rs1, 1 = PC
sel_opB  out  1  0 = rs2, 1 = imm
is_stype  out  1  store instruction
wr_en  out  1  register-file write enable
rs1  out  5  source register A
rs2  out  5  source register B
rd  out  5  destination register
imm  out  32  expanded, sign- or zero-extended immediate
jt  out  20  imm[20:1] for J and branch formats, 0 otherwise

Behaviour:
Clock/reset: single clock `clk`; reset `nrst` is asynchronous and active-low.
- nrst=0: every output is 0 immediately, with no clock needed.
- Otherwise the registered outputs load the combinational decode of inst on every rising clk. Latency is 1 cycle. There is no enable and no stall input.
- Compact register fields (3 bits) map to x8..x15, i.e. the index is 8 plus the field value.
- Unused rs1, rs2 or rd fields are 0. Defaults are ADD, imm=0, jt=0.

Decode by quadrant inst[1:0] and funct3 inst[15:13]:
- Q0 C.ADDI4SPN: rd=x(8+inst[4:2]), rs1=x2, imm=zext{inst[10:7],inst[12:11],inst[5],inst[6],00}. ADD, sel_opB=1, wr_en=1, imm_select=I. An immediate value of 0 is reserved and decodes to NOP.
- Q0 C.LW: rs1=x(8+inst[9:7]), rd=x(8+inst[4:2]), imm=zext{inst[5],inst[12:10],inst[6],00}. dm_select=010, sel_data=01, wr_en=1, sel_opB=1, imm_select=I.
- Q0 C.SW: rs1=x(8+inst[9:7]), rs2=x(8+inst[4:2]), same immediate as C.LW. is_stype=1, store_select=10, sel_opB=1, imm_select=S, wr_en=0.
- Q1 C.ADDI/C.NOP and C.LI:
  - imm=sext{inst[12],inst[6:2]}, rd=inst[11:7].
  - C.ADDI: rs1=rd. C.LI: rs1=x0.
  - ADD, sel_opB=1, wr_en=1, imm_select=I.
- Q1 C.JAL and C.J:
  - imm=sext{inst[12],inst[8],inst[10:9],inst[6],inst[7],inst[2],inst[11],inst[5:3],0}.
  - imm_select=J, sel_opA=1, sel_opB=1.
  - C.JAL: rd=x1, wr_en=1, sel_data=10. C.J: wr_en=0.
- Q1 funct3=011:
  - rd=x2 is C.ADDI16SP: imm=sext{inst[12],inst[4:3],inst[5],inst[2],inst[6],0000}, rs1=x2, ADD.
  - Any other rd is C.LUI: imm=sext{inst[12],inst[6:2]}<<12, alu_op=pass-B, imm_select=U.
  - Both write (wr_en=1). An immediate of 0 is reserved and decodes to NOP.
- Q1 funct3=100, with rd=rs1=x(8+inst[9:7]):
  - inst[11:10] = 00 SRLI / 01 SRAI: shamt=inst[6:2]. inst[12]=1 is reserved and decodes to NOP.
  - inst[11:10] = 10 ANDI: imm=sext 6-bit.
  - inst[11:10] = 11 with inst[12]=0: SUB/XOR/OR/AND selected by inst[6:5], rs2=x(8+inst[4:2]), sel_opB=0. inst[12]=1 decodes to NOP.
- Q1 C.BEQZ and C.BNEZ:
  - rs1=x(8+inst[9:7]), rs2=x0, SUB, wr_en=0.
  - imm=sext{inst[12],inst[6:5],inst[2],inst[11:10],inst[4:3],0}.
  - imm_select = 011 (BEQZ) or 110 (BNEZ).
- Q2 C.SLLI: rd=rs1=inst[11:7], shamt=inst[6:2], SLL, wr_en=1. inst[12]=1 is reserved.
- Q2 C.LWSP: rs1=x2, rd=inst[11:7], imm=zext{inst[3:2],inst[12],inst[6:4],00}, load controls as C.LW. rd=0 is reserved.
- Q2 funct3=100, with r=inst[11:7] and s=inst[6:2]:
  - inst[12]=0, s=0: C.JR, rs1=r, imm_select=111, wr_en=0. r=0 is reserved.
  - inst[12]=0, s!=0: C.MV, rd=r, rs1=x0, rs2=s, ADD, wr_en=1.
  - inst[12]=1, r=0, s=0: C.EBREAK, decodes to NOP.
  - inst[12]=1, s=0, r!=0: C.JALR, rs1=r, rd=x1, sel_data=10, wr_en=1, imm_select=111.
  - inst[12]=1, s!=0: C.ADD, rd=rs1=r, rs2=s, wr_en=1.
- Q2 C.SWSP: rs1=x2, rs2=inst[6:2], imm=zext{inst[8:7],inst[12:9],00}, store controls as C.SW.
- inst=16'h0000, and all other unlisted encodings: is_compressed=1, everything else 0.
- inst[1:0]=11: is_compressed=0, everything else 0.

Test Plan:
- Reset: nrst=0 with inst=16'h4515 and clk running -> all outputs 0. Release nrst -> the next edge loads the decode.
- 16'h4515 (C.LI x10,5) -> after 1 edge: rd=10, rs1=0, imm=5, alu_op=0, sel_opB=1, wr_en=1, imm_select=001, is_compressed=1.
- 16'h4188 (C.LW x10,0(x11)) -> rd=10, rs1=11, imm=0, dm_select=010, sel_data=01, wr_en=1.
- 16'hBFFD (C.J -2) -> imm=32'hFFFFFFFE, jt=20'hFFFFF, imm_select=101, sel_opA=1, wr_en=0.
- 16'h9532 (C.ADD x10,x12) -> rd=10, rs1=10, rs2=12, alu_op=0, sel_opB=0, wr_en=1.
- 16'h0013 -> is_compressed=0, all else 0. 16'h0000 -> is_compressed=1, all else 0. Back-to-back changes each update one cycle later.

Source files
------------

// File: rtl/rvc_expand_decoder.sv
// rvc_expand_decoder: RV32C halfword decoded into the 32-bit control bundle, registered one cycle
module rvc_expand_decoder (
    input  logic        clk,
    input  logic        nrst,
    input  logic [15:0] inst,
    output logic        is_compressed,
    output logic [2:0]  dm_select,
    output logic [2:0]  imm_select,
    output logic [1:0]  sel_data,
    output logic [1:0]  store_select,
    output logic [3:0]  alu_op,
    output logic        sel_opA,
    output logic        sel_opB,
    output logic        is_stype,
    output logic        wr_en,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic [19:0] jt
);
    logic        is_compressed_d, is_compressed_q;
    logic [2:0]  dm_select_d, dm_select_q;
    logic [2:0]  imm_select_d, imm_select_q;
    logic [1:0]  sel_data_d, sel_data_q;
    logic [1:0]  store_select_d, store_select_q;
    logic [3:0]  alu_op_d, alu_op_q;
    logic        sel_opA_d, sel_opA_q;
    logic        sel_opB_d, sel_opB_q;
    logic        is_stype_d, is_stype_q;
    logic        wr_en_d, wr_en_q;
    logic [4:0]  rs1_d, rs1_q;
    logic [4:0]  rs2_d, rs2_q;
    logic [4:0]  rd_d, rd_q;
    logic [31:0] imm_d, imm_q;
    logic [19:0] jt_d, jt_q;
    logic [4:0]  rp1, rp2, r, s;
    logic [31:0] imm6;
    assign rp1  = {2'b01, inst[9:7]};
    assign rp2  = {2'b01, inst[4:2]};
    assign r    = inst[11:7];
    assign s    = inst[6:2];
    assign imm6 = {{26{inst[12]}}, inst[12], inst[6:2]};

    // Combinational decode of the halfword; anything not matched stays NOP
    always_comb begin
        is_compressed_d = inst[1:0] != 2'b11;
        dm_select_d     = 3'd0;
        imm_select_d    = 3'd0;
        sel_data_d      = 2'd0;
        store_select_d  = 2'd0;
        alu_op_d        = 4'd0;
        sel_opA_d       = 1'b0;
        sel_opB_d       = 1'b0;
        is_stype_d      = 1'b0;
        wr_en_d         = 1'b0;
        rs1_d           = 5'd0;
        rs2_d           = 5'd0;
        rd_d            = 5'd0;
        imm_d           = 32'd0;
        case ({inst[1:0], inst[15:13]})
            5'b00_000: if (|inst[12:5]) begin
                rd_d = rp2; rs1_d = 5'd2; sel_opB_d = 1'b1; wr_en_d = 1'b1; imm_select_d = 3'b001;
                imm_d = {22'd0, inst[10:7], inst[12:11], inst[5], inst[6], 2'b00};
            end
            5'b00_010: begin
                rs1_d = rp1; rd_d = rp2; dm_select_d = 3'b010; sel_data_d = 2'b01;
                wr_en_d = 1'b1; sel_opB_d = 1'b1; imm_select_d = 3'b001;
                imm_d = {25'd0, inst[5], inst[12:10], inst[6], 2'b00};
            end
            5'b00_110: begin
                rs1_d = rp1; rs2_d = rp2; is_stype_d = 1'b1; store_select_d = 2'b10;
                sel_opB_d = 1'b1; imm_select_d = 3'b010;
                imm_d = {25'd0, inst[5], inst[12:10], inst[6], 2'b00};
            end
            5'b01_000, 5'b01_010: begin
                rd_d = r; rs1_d = inst[14] ? 5'd0 : r; imm_d = imm6;
                sel_opB_d = 1'b1; wr_en_d = 1'b1; imm_select_d = 3'b001;
            end
            5'b01_001, 5'b01_101: begin
                imm_d = {{21{inst[12]}}, inst[8], inst[10:9], inst[6], inst[7], inst[2], inst[11], inst[5:3], 1'b0};
                imm_select_d = 3'b101; sel_opA_d = 1'b1; sel_opB_d = 1'b1;
                if (!inst[15]) begin
                    rd_d = 5'd1; wr_en_d = 1'b1; sel_data_d = 2'b10;
                end
            end
            5'b01_011: if (|{inst[12], inst[6:2]}) begin
                wr_en_d = 1'b1; sel_opB_d = 1'b1; rd_d = r;
                if (r == 5'd2) begin
                    rs1_d = 5'd2; imm_select_d = 3'b001;
                    imm_d = {{23{inst[12]}}, inst[4:3], inst[5], inst[2], inst[6], 4'b0000};
                end else begin
                    alu_op_d = 4'd10; imm_select_d = 3'b100;
                    imm_d = {{14{inst[12]}}, inst[12], inst[6:2], 12'd0};
                end
            end
            5'b01_100: if (!(inst[12] && inst[11:10] != 2'b10)) begin
                rd_d = rp1; rs1_d = rp1; wr_en_d = 1'b1;
                if (inst[11:10] == 2'b11) begin
                    rs2_d = rp2;
                    alu_op_d = inst[6] ? (inst[5] ? 4'd2 : 4'd3) : (inst[5] ? 4'd4 : 4'd1);
                end else begin
                    sel_opB_d = 1'b1; imm_select_d = 3'b001;
                    imm_d = inst[11] ? imm6 : {27'd0, inst[6:2]};
                    alu_op_d = inst[11] ? 4'd2 : (inst[10] ? 4'd7 : 4'd6);
                end
            end
            5'b01_110, 5'b01_111: begin
                rs1_d = rp1; alu_op_d = 4'd1; imm_select_d = inst[13] ? 3'b110 : 3'b011;
                imm_d = {{24{inst[12]}}, inst[6:5], inst[2], inst[11:10], inst[4:3], 1'b0};
            end
            5'b10_000: if (!inst[12]) begin
                rd_d = r; rs1_d = r; imm_d = {27'd0, s}; sel_opB_d = 1'b1;
                imm_select_d = 3'b001; alu_op_d = 4'd5; wr_en_d = 1'b1;
            end
            5'b10_010: if (r != 5'd0) begin
                rs1_d = 5'd2; rd_d = r; dm_select_d = 3'b010; sel_data_d = 2'b01;
                wr_en_d = 1'b1; sel_opB_d = 1'b1; imm_select_d = 3'b001;
                imm_d = {24'd0, inst[3:2], inst[12], inst[6:4], 2'b00};
            end
            5'b10_100: if (s != 5'd0) begin
                rd_d = r; rs2_d = s; wr_en_d = 1'b1; rs1_d = inst[12] ? r : 5'd0;
            end else if (r != 5'd0) begin
                rs1_d = r; imm_select_d = 3'b111;
                if (inst[12]) begin
                    rd_d = 5'd1; sel_data_d = 2'b10; wr_en_d = 1'b1;
                end
            end
            5'b10_110: begin
                rs1_d = 5'd2; rs2_d = s; is_stype_d = 1'b1; store_select_d = 2'b10;
                sel_opB_d = 1'b1; imm_select_d = 3'b010;
                imm_d = {24'd0, inst[8:7], inst[12:9], 2'b00};
            end
            default: ;
        endcase
        jt_d = (imm_select_d inside {3'b011, 3'b101, 3'b110}) ? imm_d[20:1] : 20'd0;
    end

    // Register the decode bundle; asynchronous clear to NOP
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            is_compressed_q <= 1'b0;
            dm_select_q     <= 3'd0;
            imm_select_q    <= 3'd0;
            sel_data_q      <= 2'd0;
            store_select_q  <= 2'd0;
            alu_op_q        <= 4'd0;
            sel_opA_q       <= 1'b0;
            sel_opB_q       <= 1'b0;
            is_stype_q      <= 1'b0;
            wr_en_q         <= 1'b0;
            rs1_q           <= 5'd0;
            rs2_q           <= 5'd0;
            rd_q            <= 5'd0;
            imm_q           <= 32'd0;
            jt_q            <= 20'd0;
        end else begin
            is_compressed_q <= is_compressed_d;
            dm_select_q     <= dm_select_d;
            imm_select_q    <= imm_select_d;
            sel_data_q      <= sel_data_d;
            store_select_q  <= store_select_d;
            alu_op_q        <= alu_op_d;
            sel_opA_q       <= sel_opA_d;
            sel_opB_q       <= sel_opB_d;
            is_stype_q      <= is_stype_d;
            wr_en_q         <= wr_en_d;
            rs1_q           <= rs1_d;
            rs2_q           <= rs2_d;
            rd_q            <= rd_d;
            imm_q           <= imm_d;
            jt_q            <= jt_d;
        end
    end

    assign is_compressed = is_compressed_q;
    assign dm_select     = dm_select_q;
    assign imm_select    = imm_select_q;
    assign sel_data      = sel_data_q;
    assign store_select  = store_select_q;
    assign alu_op        = alu_op_q;
    assign sel_opA       = sel_opA_q;
    assign sel_opB       = sel_opB_q;
    assign is_stype      = is_stype_q;
    assign wr_en         = wr_en_q;
    assign rs1           = rs1_q;
    assign rs2           = rs2_q;
    assign rd            = rd_q;
    assign imm           = imm_q;
    assign jt            = jt_q;
endmodule

// File: tb/tb_rvc_expand_decoder.sv
// tb_rvc_expand_decoder: directed RV32C decode vectors with hand-computed control bundles
module tb_rvc_expand_decoder;
    typedef struct packed {
        logic        is_compressed;
        logic [2:0]  dm_select;
        logic [2:0]  imm_select;
        logic [1:0]  sel_data;
        logic [1:0]  store_select;
        logic [3:0]  alu_op;
        logic        sel_opA;
        logic        sel_opB;
        logic        is_stype;
        logic        wr_en;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [19:0] jt;
    } out_t;

    logic clk = 1'b0;
    logic nrst;
    logic [15:0] inst;
    out_t obs;
    out_t e;
    out_t prev;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rvc_expand_decoder dut (
        .clk(clk), .nrst(nrst), .inst(inst),
        .is_compressed(obs.is_compressed), .dm_select(obs.dm_select), .imm_select(obs.imm_select),
        .sel_data(obs.sel_data), .store_select(obs.store_select), .alu_op(obs.alu_op),
        .sel_opA(obs.sel_opA), .sel_opB(obs.sel_opB), .is_stype(obs.is_stype), .wr_en(obs.wr_en),
        .rs1(obs.rs1), .rs2(obs.rs2), .rd(obs.rd), .imm(obs.imm), .jt(obs.jt)
    );

    function automatic out_t nop_c();
        out_t t = '0;
        t.is_compressed = 1'b1;
        return t;
    endfunction

    task automatic chk(input string tag, input out_t x);
        n_cmp++;
        assert (obs === x) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, x);
        end
    endtask

    task automatic step(input logic [15:0] v);
        @(negedge clk);
        inst = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst = 1'b0;
        inst = 16'h4515;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", out_t'(0));
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        e = nop_c(); e.rd = 5'd10; e.imm = 32'd5; e.sel_opB = 1'b1; e.wr_en = 1'b1; e.imm_select = 3'b001;
        chk("c_li", e);
        step(16'h4188);
        e = nop_c(); e.rd = 5'd10; e.rs1 = 5'd11; e.dm_select = 3'b010; e.sel_data = 2'b01;
        e.wr_en = 1'b1; e.sel_opB = 1'b1; e.imm_select = 3'b001;
        chk("c_lw", e);
        step(16'hBFFD);
        e = nop_c(); e.imm = 32'hFFFFFFFE; e.jt = 20'hFFFFF; e.imm_select = 3'b101;
        e.sel_opA = 1'b1; e.sel_opB = 1'b1;
        chk("c_j", e);
        step(16'h9532);
        e = nop_c(); e.rd = 5'd10; e.rs1 = 5'd10; e.rs2 = 5'd12; e.wr_en = 1'b1;
        chk("c_add", e);
        prev = e;
        @(negedge clk);
        inst = 16'hC044;
        #1;
        chk("hold_before_edge", prev);
        @(posedge clk);
        #1;
        e = nop_c(); e.rs1 = 5'd8; e.rs2 = 5'd9; e.imm = 32'd4; e.is_stype = 1'b1;
        e.store_select = 2'b10; e.sel_opB = 1'b1; e.imm_select = 3'b010;
        chk("c_sw", e);
        step(16'h8C05);
        e = nop_c(); e.rd = 5'd8; e.rs1 = 5'd8; e.rs2 = 5'd9; e.alu_op = 4'd1; e.wr_en = 1'b1;
        chk("c_sub", e);
        step(16'hFC7D);
        e = nop_c(); e.rs1 = 5'd8; e.alu_op = 4'd1; e.imm = 32'hFFFFFFFE; e.jt = 20'hFFFFF;
        e.imm_select = 3'b110;
        chk("c_bnez", e);
        step(16'h6285);
        e = nop_c(); e.rd = 5'd5; e.imm = 32'h00001000; e.alu_op = 4'd10; e.sel_opB = 1'b1;
        e.imm_select = 3'b100; e.wr_en = 1'b1;
        chk("c_lui", e);
        step(16'h9282);
        e = nop_c(); e.rs1 = 5'd5; e.rd = 5'd1; e.sel_data = 2'b10; e.wr_en = 1'b1; e.imm_select = 3'b111;
        chk("c_jalr", e);
        step(16'h9405);
        chk("srai_reserved", nop_c());
        step(16'h6101);
        chk("addi16sp_zero", nop_c());
        step(16'h0013);
        chk("not_compressed", out_t'(0));
        step(16'h0000);
        chk("all_zero", nop_c());
        step(16'h4515);
        e = nop_c(); e.rd = 5'd10; e.imm = 32'd5; e.sel_opB = 1'b1; e.wr_en = 1'b1; e.imm_select = 3'b001;
        chk("c_li_again", e);
        nrst = 1'b0;
        #1;
        chk("async_reset", out_t'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
